// File: rtl/mouse_receiver_if.sv
// Line-side inputs and byte-side results of the PS/2 mouse receive path.
interface mouse_receiver_if;
  logic       CLK_MOUSE_IN;
  logic       DATA_MOUSE_IN;
  logic       READ_ENABLE;
  logic [7:0] BYTE_READ;
  logic [1:0] BYTE_ERROR_CODE;
  logic       BYTE_READY;
  logic       BUSY;

  modport slave (
    input  CLK_MOUSE_IN, DATA_MOUSE_IN, READ_ENABLE,
    output BYTE_READ, BYTE_ERROR_CODE, BYTE_READY, BUSY
  );

  modport master (
    output CLK_MOUSE_IN, DATA_MOUSE_IN, READ_ENABLE,
    input  BYTE_READ, BYTE_ERROR_CODE, BYTE_READY, BUSY
  );
endinterface

// File: rtl/mouse_receiver.sv
// PS/2 device-to-host deserialiser: start, 8 data bits LSB first, odd parity, stop.
// Samples DATA on each falling edge of the mouse clock; aborts on timeout or READ_ENABLE low.
module mouse_receiver #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic             CLK,
  input  logic             RESET,
  mouse_receiver_if.slave  bus
);

  localparam int unsigned TMO_W = 16;
  localparam int unsigned BIT_W = 3;
  localparam logic [TMO_W-1:0] TMO_LIM  = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(7);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t           state, state_nxt;
  logic             clk_dly;
  logic             fall_c;
  logic [BIT_W-1:0] bit_cnt, bit_cnt_nxt;
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
  logic [7:0]       shift, shift_nxt;
  logic             parity_bit, parity_nxt;
  logic [7:0]       byte_q, byte_nxt;
  logic [1:0]       err_q, err_nxt;
  logic             ready_q, ready_nxt;

  assign fall_c = clk_dly & ~bus.CLK_MOUSE_IN;

  // State and datapath registers; clk_dly resets high so no edge is seen on release.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      clk_dly    <= 1'b1;
      bit_cnt    <= '0;
      tmo_cnt    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
      byte_q     <= '0;
      err_q      <= '0;
      ready_q    <= 1'b0;
    end else begin
      state      <= state_nxt;
      clk_dly    <= bus.CLK_MOUSE_IN;
      bit_cnt    <= bit_cnt_nxt;
      tmo_cnt    <= tmo_cnt_nxt;
      shift      <= shift_nxt;
      parity_bit <= parity_nxt;
      byte_q     <= byte_nxt;
      err_q      <= err_nxt;
      ready_q    <= ready_nxt;
    end
  end

  // Next-state: abort beats Fall, Fall beats timeout.
  always_comb begin
    state_nxt   = state;
    bit_cnt_nxt = bit_cnt;
    tmo_cnt_nxt = tmo_cnt;
    shift_nxt   = shift;
    parity_nxt  = parity_bit;
    byte_nxt    = byte_q;
    err_nxt     = err_q;
    ready_nxt   = 1'b0;

    if (state == IDLE) begin
      bit_cnt_nxt = '0;
      tmo_cnt_nxt = '0;
      if (fall_c && bus.READ_ENABLE && !bus.DATA_MOUSE_IN) begin
        state_nxt = DATA;
      end
    end else if (!bus.READ_ENABLE) begin
      state_nxt   = IDLE;
      bit_cnt_nxt = '0;
      tmo_cnt_nxt = '0;
    end else if (fall_c) begin
      tmo_cnt_nxt = '0;
      case (state)
        DATA: begin
          shift_nxt = {bus.DATA_MOUSE_IN, shift[7:1]};
          if (bit_cnt == LAST_BIT) begin
            state_nxt   = PARITY;
            bit_cnt_nxt = '0;
          end else begin
            bit_cnt_nxt = BIT_W'(bit_cnt + BIT_W'(1));
          end
        end
        PARITY: begin
          parity_nxt = bus.DATA_MOUSE_IN;
          state_nxt  = STOP;
        end
        STOP: begin
          state_nxt = IDLE;
          byte_nxt  = shift;
          err_nxt   = {~bus.DATA_MOUSE_IN, parity_bit != (~^shift)};
          ready_nxt = 1'b1;
        end
        default: ;
      endcase
    end else if (tmo_cnt == TMO_LIM) begin
      state_nxt   = IDLE;
      bit_cnt_nxt = '0;
      tmo_cnt_nxt = '0;
    end else begin
      tmo_cnt_nxt = TMO_W'(tmo_cnt + TMO_W'(1));
    end
  end

  assign bus.BYTE_READ       = byte_q;
  assign bus.BYTE_ERROR_CODE = err_q;
  assign bus.BYTE_READY      = ready_q;
  assign bus.BUSY            = (state != IDLE);

endmodule

// File: tb/tb_mouse_receiver.sv
// Directed bench for mouse_receiver: good frames, parity/stop errors, timeout, abort, reset, glitch.
module tb_mouse_receiver;

  localparam int TMO  = 300;
  localparam int HALF = 40;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   ready_cnt;
  int   busy_cnt;
  int   r0;
  int   b0;

  mouse_receiver_if bus ();

  mouse_receiver #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK   (clk),
    .RESET (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.BYTE_READY === 1'b1) ready_cnt++;
    if (bus.BUSY === 1'b1) busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    bus.DATA_MOUSE_IN = b;
    repeat (HALF) @(negedge clk);
    bus.CLK_MOUSE_IN = 1'b0;
    repeat (HALF) @(negedge clk);
    bus.CLK_MOUSE_IN = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(s);
    bus.DATA_MOUSE_IN = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad = 0;
    ready_cnt = 0;
    busy_cnt = 0;
    bus.CLK_MOUSE_IN = 1'b1;
    bus.DATA_MOUSE_IN = 1'b1;
    bus.READ_ENABLE = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_byte", 32'(bus.BYTE_READ), 32'h00);
    check("rst_err", 32'(bus.BYTE_ERROR_CODE), 32'h0);
    check("rst_ready", 32'(bus.BYTE_READY), 32'h0);
    check("rst_busy", 32'(bus.BUSY), 32'h0);

    // 0xFA, good parity and stop
    r0 = ready_cnt; b0 = busy_cnt;
    send_frame(8'hFA, 1'b1, 1'b1);
    check("fa_byte", 32'(bus.BYTE_READ), 32'hFA);
    check("fa_err", 32'(bus.BYTE_ERROR_CODE), 32'h0);
    check("fa_pulses", 32'(ready_cnt - r0), 32'd1);
    check("fa_busy_cycles", 32'(busy_cnt - b0), 32'(20 * HALF));
    check("fa_busy_after", 32'(bus.BUSY), 32'h0);

    // parity error then stop error
    r0 = ready_cnt;
    send_frame(8'h00, 1'b0, 1'b1);
    check("par_byte", 32'(bus.BYTE_READ), 32'h00);
    check("par_err", 32'(bus.BYTE_ERROR_CODE), 32'h1);
    send_frame(8'h08, 1'b0, 1'b0);
    check("stop_byte", 32'(bus.BYTE_READ), 32'h08);
    check("stop_err", 32'(bus.BYTE_ERROR_CODE), 32'h2);
    check("err_pulses", 32'(ready_cnt - r0), 32'd2);

    // timeout after start + 4 data bits
    r0 = ready_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    repeat (TMO + 1 - HALF) @(negedge clk);
    check("tmo_busy_before", 32'(bus.BUSY), 32'h1);
    @(negedge clk);
    check("tmo_busy_drop", 32'(bus.BUSY), 32'h0);
    repeat (9) @(negedge clk);
    check("tmo_pulses", 32'(ready_cnt - r0), 32'd0);
    check("tmo_byte_held", 32'(bus.BYTE_READ), 32'h08);
    check("tmo_err_held", 32'(bus.BYTE_ERROR_CODE), 32'h2);
    send_frame(8'hAA, 1'b1, 1'b1);
    check("aa_byte", 32'(bus.BYTE_READ), 32'hAA);
    check("aa_err", 32'(bus.BYTE_ERROR_CODE), 32'h0);
    check("aa_pulses", 32'(ready_cnt - r0), 32'd1);

    // READ_ENABLE abort mid-frame, then a frame while disabled
    r0 = ready_cnt;
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    bus.READ_ENABLE = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(bus.BUSY), 32'h0);
    b0 = busy_cnt;
    send_frame(8'hF4, 1'b0, 1'b1);
    check("dis_busy_cycles", 32'(busy_cnt - b0), 32'd0);
    check("dis_pulses", 32'(ready_cnt - r0), 32'd0);
    check("dis_byte_held", 32'(bus.BYTE_READ), 32'hAA);
    bus.READ_ENABLE = 1'b1;
    repeat (HALF) @(negedge clk);

    // reset mid-frame
    r0 = ready_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mrst_busy", 32'(bus.BUSY), 32'h0);
    check("mrst_byte", 32'(bus.BYTE_READ), 32'h00);
    check("mrst_err", 32'(bus.BYTE_ERROR_CODE), 32'h0);
    repeat (20) @(negedge clk);
    check("mrst_no_fall", 32'(bus.BUSY), 32'h0);
    b0 = busy_cnt;
    send_frame(8'h55, 1'b1, 1'b1);
    check("b55_byte", 32'(bus.BYTE_READ), 32'h55);
    check("b55_err", 32'(bus.BYTE_ERROR_CODE), 32'h0);
    check("b55_pulses", 32'(ready_cnt - r0), 32'd1);
    check("b55_busy_cycles", 32'(busy_cnt - b0), 32'(20 * HALF));

    // falling clock with DATA high in IDLE is ignored
    r0 = ready_cnt;
    send_bit(1'b1);
    repeat (HALF) @(negedge clk);
    check("glitch_busy", 32'(bus.BUSY), 32'h0);
    check("glitch_pulses", 32'(ready_cnt - r0), 32'd0);
    send_frame(8'h01, 1'b0, 1'b1);
    check("b01_byte", 32'(bus.BYTE_READ), 32'h01);
    check("b01_err", 32'(bus.BYTE_ERROR_CODE), 32'h0);
    check("b01_pulses", 32'(ready_cnt - r0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mouse_receiver.md
Name: mouse_receiver

Overview:
PS/2 device-to-host receive path for the mouse interface. The block watches the open-collector mouse CLK/DATA lines and deserialises one 11-bit frame: start, 8 data bits LSB first, odd parity, stop. It presents the byte with error flags to the mouse master state machine. It is the counterpart of the host-to-device transmitter and shares the same tri-state line pair, but it only ever reads the lines.

Parameters:
TIMEOUT_CYCLES, 50000, CLK cycles allowed between consecutive mouse-clock falling edges inside a frame (500 us at 100 MHz); must fit in 16 bits.

Ports:
CLK  in  1  system clock, 100 MHz
RESET  in  1  synchronous, active-high reset
CLK_MOUSE_IN  in  1  sampled PS/2 clock line
DATA_MOUSE_IN  in  1  sampled PS/2 data line
READ_ENABLE  in  1  1 = reception allowed; 0 = hold/abort (master drives low while the transmitter owns the bus)
BYTE_READ  out  8  last completed received byte
BYTE_ERROR_CODE  out  2  [0] parity error, [1] stop-bit error, for the last completed frame
BYTE_READY  out  1  one-cycle pulse: BYTE_READ/BYTE_ERROR_CODE updated
BUSY  out  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset (synchronous, active-high): state IDLE; BYTE_READ=0x00; BYTE_ERROR_CODE=2'b00; BYTE_READY=0; BUSY=0; bit counter=0; timeout counter=0; shift register=0. The registered copy of the clock line, ClkDly, resets to 1 so that no false edge is seen after reset.
- Edge detect: ClkDly <= CLK_MOUSE_IN every cycle. Fall = ClkDly & ~CLK_MOUSE_IN. DATA_MOUSE_IN is sampled in the Fall cycle. All line activity other than Fall is ignored.
- IDLE: on Fall with READ_ENABLE=1 and DATA=0 (start bit), go to DATA with bit counter=0. On Fall with DATA=1, stay in IDLE (framing glitch, no output).
- DATA: on each Fall, shift the register right and load DATA into bit 7. After the 8th Fall (counter==7), go to PARITY and clear the counter. Otherwise increment the counter.
- PARITY: on Fall, store p = DATA and go to STOP.
- STOP: on Fall, go to IDLE and load the outputs:
  - BYTE_READ <= shift register
  - BYTE_ERROR_CODE[0] <= (p != ~^data)
  - BYTE_ERROR_CODE[1] <= ~DATA
  - BYTE_READY=1 in the cycle after the stop-bit Fall, for exactly one cycle
- Error frames still pulse BYTE_READY; the master inspects BYTE_ERROR_CODE.
- BYTE_READ and BYTE_ERROR_CODE hold their values until the next completed frame. Aborted frames never change them.
- Timeout: in any state != IDLE, the 16-bit counter increments each cycle and clears on Fall. When the counter == TIMEOUT_CYCLES, the next state is IDLE, the counter clears, and there is no BYTE_READY. If Fall and the timeout coincide, Fall wins.
- READ_ENABLE=0 mid-frame: next state is IDLE, counters clear, there is no BYTE_READY, and the outputs are held.
- Simultaneous RESET and Fall: reset wins.
- BUSY is combinational from state (state != IDLE).
- Latency: the stop-bit Fall cycle is N, and BYTE_READY rises at N+1. The line-edge to Fall detection adds 1 cycle.

Test Plan:
1. Send 0xFA (bits 0,1,0,1,1,1,1,1; parity=1; stop=1), 40 us per half mouse-clock -> one BYTE_READY pulse; BYTE_READ=0xFA; BYTE_ERROR_CODE=2'b00; BUSY high from start-bit Fall until the stop-bit Fall.
2. Send 0x00 with parity=0 (wrong; correct is 1) -> BYTE_READ=0x00, BYTE_ERROR_CODE=2'b01. Then send 0x08 with stop=0 -> BYTE_READ=0x08, BYTE_ERROR_CODE=2'b10.
3. Send start plus 4 data bits, then hold the clock high for TIMEOUT_CYCLES+10 -> BUSY drops exactly TIMEOUT_CYCLES+1 cycles after the last Fall; no BYTE_READY; BYTE_READ unchanged. A following 0xAA frame is received cleanly.
4. Deassert READ_ENABLE after the 3rd data bit -> BUSY=0 next cycle; no pulse. With READ_ENABLE=0, a full 0xF4 frame -> ignored.
5. Assert RESET for 1 cycle mid-frame, then send 0x55 -> outputs cleared by reset; 0x55 received with code 2'b00; no spurious Fall right after reset.
6. Clock falls while DATA=1 in IDLE -> stays IDLE; the subsequent valid 0x01 frame reports BYTE_READ=0x01.
